// File: rtl/sram_bus_arbiter_pkg.sv
// rtl/sram_bus_arbiter_pkg.sv - shared types for the inst/data SRAM bus arbiter
package sram_bus_arbiter_pkg;

    typedef logic [31:0] word_t;
    typedef logic [1:0]  size_t;

    typedef enum logic {OWN_I, OWN_D} bus_owner_t;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_I, ARB_GNT_D} arb_state_t;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// rtl/sram_bus_arbiter_if.sv - SRAM-like request/response bus
interface sram_bus_arbiter_if;
    import sram_bus_arbiter_pkg::*;

    logic  req;
    logic  wr;
    size_t size;
    word_t addr;
    word_t wdata;
    logic  addr_ok;
    logic  data_ok;
    word_t rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_bus_arbiter_owner_fifo.sv
// rtl/sram_bus_arbiter_owner_fifo.sv - in-order queue of bus owners awaiting data_ok
module owner_fifo
    import sram_bus_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  bus_owner_t push_owner,
    input  logic       pop,
    output bus_owner_t head,
    output logic       full,
    output logic       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    bus_owner_t     slots [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head  = slots[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            slots[wr_ptr] <= push_owner;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - shares one SRAM-like bus between inst and data ports
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_bus_arbiter_if.slave    inst_bus,
    sram_bus_arbiter_if.slave    data_bus,
    sram_bus_arbiter_if.master   mem_bus,
    output logic                 proto_err
);

    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    arb_state_t     state;
    logic [SCW-1:0] starve_cnt;

    logic       fifo_full;
    logic       fifo_empty;
    bus_owner_t head_owner;

    logic       pick_valid;
    bus_owner_t pick_owner;
    logic       grant_valid;
    bus_owner_t owner;
    logic       sel_d;
    logic       owner_req;
    logic       m_req;
    logic       accept;
    logic       resp_valid;

    // Data wins unless inst has already watched STARVE_LIMIT data grants go by.
    always_comb begin
        pick_valid = 1'b0;
        pick_owner = OWN_I;
        if (!fifo_full) begin
            if (data_bus.req && !(inst_bus.req && starve_cnt == SCW'(STARVE_LIMIT))) begin
                pick_valid = 1'b1;
                pick_owner = OWN_D;
            end else if (inst_bus.req) begin
                pick_valid = 1'b1;
                pick_owner = OWN_I;
            end
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        owner       = OWN_I;
        case (state)
            ARB_GNT_I: begin grant_valid = 1'b1; owner = OWN_I; end
            ARB_GNT_D: begin grant_valid = 1'b1; owner = OWN_D; end
            default:   begin grant_valid = pick_valid; owner = pick_owner; end
        endcase
    end

    assign sel_d      = (owner == OWN_D);
    assign owner_req  = sel_d ? data_bus.req : inst_bus.req;
    assign m_req      = grant_valid && owner_req && !fifo_full && !reset;
    assign accept     = m_req && mem_bus.addr_ok;
    assign resp_valid = mem_bus.data_ok && !fifo_empty && !reset;

    assign mem_bus.req   = m_req;
    assign mem_bus.wr    = sel_d ? data_bus.wr    : inst_bus.wr;
    assign mem_bus.size  = sel_d ? data_bus.size  : inst_bus.size;
    assign mem_bus.addr  = sel_d ? data_bus.addr  : inst_bus.addr;
    assign mem_bus.wdata = sel_d ? data_bus.wdata : inst_bus.wdata;

    assign inst_bus.addr_ok = accept && !sel_d;
    assign data_bus.addr_ok = accept && sel_d;
    assign inst_bus.data_ok = resp_valid && (head_owner == OWN_I);
    assign data_bus.data_ok = resp_valid && (head_owner == OWN_D);
    assign inst_bus.rdata   = mem_bus.rdata;
    assign data_bus.rdata   = mem_bus.rdata;

    owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_owner (owner),
        .pop        (resp_valid),
        .head       (head_owner),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // After an accept we fall back to IDLE, whose grant is combinational, so there is no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            starve_cnt <= '0;
            proto_err  <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid && !accept) begin
                        state <= (pick_owner == OWN_D) ? ARB_GNT_D : ARB_GNT_I;
                    end
                end
                default: begin
                    if (accept || !owner_req) begin
                        state <= ARB_IDLE;
                    end
                end
            endcase

            if ((accept && !sel_d) || !inst_bus.req) begin
                starve_cnt <= '0;
            end else if (accept && starve_cnt != SCW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (mem_bus.data_ok && fifo_empty) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule
